// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and arbiter state encoding
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_HOLD
    } arb_state_e;

    // 115200 baud from the 50 MHz system clock
    localparam int CLKS_PER_BIT     = 434;
    localparam int WAIT_TIMEOUT_DEF = 8;
    localparam int HOLD_TIMEOUT_DEF = 65535;
    localparam int ARB_CNT_W        = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority one-hot pick starting after ptr_i
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = PW'((int'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx; packet lock under UART_TX_ARB_LOCK_EN
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF,
    parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
) (
    input  logic                 clk_50M,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic                 o_tx_avail,
    output logic [7:0]           o_tx_byte,
    input  logic                 i_tx_busy,
    input  logic                 i_tx_done,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_err
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [ARB_CNT_W-1:0] WAIT_LIM = ARB_CNT_W'(WAIT_TIMEOUT - 1);

    arb_state_e           state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [7:0]           byte_q, byte_d;
    logic [ARB_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 err_q, err_d;

    logic [NUM_REQ-1:0]   win_gnt;
    logic [PW-1:0]        win_idx;
    logic [7:0]           win_byte;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr (
        .req_i   (i_req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (win_gnt)
    );

    always_comb begin
        win_idx  = '0;
        win_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_gnt[k]) begin
                win_idx  = PW'(k);
                win_byte = i_req_data[8*k +: 8];
            end
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    localparam logic [ARB_CNT_W-1:0] HOLD_LIM = ARB_CNT_W'(HOLD_TIMEOUT - 1);

    logic       last_q, last_d;
    logic       win_last, own_last;
    logic [7:0] own_byte;

    always_comb begin
        win_last = 1'b0;
        own_last = 1'b0;
        own_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_gnt[k]) begin
                win_last = i_req_last[k];
            end
            if (ptr_q == PW'(k)) begin
                own_last = i_req_last[k];
                own_byte = i_req_data[8*k +: 8];
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^i_req_last ^ (HOLD_TIMEOUT == 0);
`endif

    // saturating so a stalled owner can never wrap back under the limit
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        byte_d  = byte_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef UART_TX_ARB_LOCK_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if ((|i_req_valid) && !i_tx_busy) begin
                    ptr_d   = win_idx;
                    byte_d  = win_byte;
`ifdef UART_TX_ARB_LOCK_EN
                    last_d  = win_last;
`endif
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q >= WAIT_LIM) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (i_tx_done) begin
`ifdef UART_TX_ARB_LOCK_EN
                    if (!last_q) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef UART_TX_ARB_LOCK_EN
            ST_HOLD: begin
                if (i_req_valid[ptr_q] && !i_tx_busy) begin
                    byte_d  = own_byte;
                    last_d  = own_last;
                    state_d = ST_LAUNCH;
                end else if (cnt_q >= HOLD_LIM) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(NUM_REQ - 1);
            byte_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef UART_TX_ARB_LOCK_EN
            last_q  <= last_d;
`endif
        end
    end

    // ptr_q always names the current owner outside IDLE
    assign o_grant     = (state_q == ST_IDLE) ? '0 : (NUM_REQ'(1) << ptr_q);
    assign o_tx_avail  = (state_q == ST_LAUNCH);
    assign o_req_ready = (state_q == ST_LAUNCH) ? o_grant : '0;
    assign o_tx_byte   = byte_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector bench with a behavioural uart_tx (4 clocks per bit)
module tb_uart_tx_arbiter;

    localparam int CPB = 4;

    logic        clk_50M = 1'b0;
    logic        i_rst;
    logic [3:0]  i_req_valid;
    logic [31:0] i_req_data;
    logic [3:0]  i_req_last;
    logic [3:0]  o_req_ready;
    logic        o_tx_avail;
    logic [7:0]  o_tx_byte;
    logic [3:0]  o_grant;
    logic        o_err;

    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic        tx_mute = 1'b0;
    logic [9:0]  sh = '0;
    logic [9:0]  rx = '0;
    int          bit_n = 0;
    int          clk_n = 0;
    logic [7:0]  last_sent = '0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          rdy_cnt [4] = '{0, 0, 0, 0};

    always #10 clk_50M = ~clk_50M;

    uart_tx_arbiter #(.NUM_REQ(4)) dut (
        .clk_50M     (clk_50M),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_tx_avail  (o_tx_avail),
        .o_tx_byte   (o_tx_byte),
        .i_tx_busy   (tx_busy),
        .i_tx_done   (tx_done),
        .o_grant     (o_grant),
        .o_err       (o_err)
    );

    // uart_tx stand-in: no reset, serialises start/8 data/stop and recovers the byte
    always @(posedge clk_50M) begin
        tx_done <= 1'b0;
        if (!tx_busy) begin
            if (o_tx_avail && !tx_mute) begin
                tx_busy <= 1'b1;
                sh      <= {1'b1, o_tx_byte, 1'b0};
                bit_n   <= 0;
                clk_n   <= 0;
            end
        end else if (clk_n == CPB - 1) begin
            clk_n <= 0;
            rx    <= {sh[0], rx[9:1]};
            sh    <= sh >> 1;
            if (bit_n == 9) begin
                tx_busy   <= 1'b0;
                tx_done   <= 1'b1;
                last_sent <= rx[9:2];
            end else begin
                bit_n <= bit_n + 1;
            end
        end else begin
            clk_n <= clk_n + 1;
        end
    end

    always @(negedge clk_50M) begin
        for (int k = 0; k < 4; k++) begin
            if (o_req_ready[k]) rdy_cnt[k] <= rdy_cnt[k] + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_avail(input int lim, output bit ok, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_50M);
            cyc++;
        end while (!o_tx_avail && cyc < lim);
        ok = o_tx_avail;
    endtask

    task automatic expect_frame(input string name, input logic [7:0] exp);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk_50M);
            cyc++;
        end while (!tx_done && cyc < 100);
        chk({name, "_done"}, 32'(tx_done), 32'd1);
        chk({name, "_byte"}, 32'(last_sent), 32'(exp));
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit ok;
        int cyc;
        int base [4];
        bit launched;
        logic [3:0] exp_f [4];

        vecs[0] = '{4'b0001, 32'h0000_0055, 4'b0001, 8'h55};
        vecs[1] = '{4'b1111, 32'hB3B2_B1B0, 4'b0010, 8'hB1};
        vecs[2] = '{4'b1001, 32'hC3C2_C1C0, 4'b1000, 8'hC3};
        vecs[3] = '{4'b1001, 32'hD3D2_D1D0, 4'b0001, 8'hD0};
        vecs[4] = '{4'b0100, 32'h00E2_0000, 4'b0100, 8'hE2};
        vecs[5] = '{4'b0011, 32'h0000_F1F0, 4'b0001, 8'hF0};
        vecs[6] = '{4'b1000, 32'h1700_0000, 4'b1000, 8'h17};
        vecs[7] = '{4'b1000, 32'h2800_0000, 4'b1000, 8'h28};
        exp_f   = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

        i_rst = 1'b1;
        i_req_valid = '0;
        i_req_data  = '0;
        i_req_last  = '0;
        repeat (3) @(negedge clk_50M);
        chk("rst_avail", 32'(o_tx_avail), 0);
        chk("rst_ready", 32'(o_req_ready), 0);
        chk("rst_byte", 32'(o_tx_byte), 0);
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_err", 32'(o_err), 0);
        i_rst = 1'b0;
        @(negedge clk_50M);

        for (int v = 0; v < 8; v++) begin
            i_req_valid = vecs[v].valid;
            i_req_data  = vecs[v].data;
            wait_avail(10, ok, cyc);
            chk($sformatf("v%0d_latency", v), 32'(cyc), 1);
            chk($sformatf("v%0d_grant", v), 32'(o_grant), 32'(vecs[v].exp_grant));
            chk($sformatf("v%0d_txbyte", v), 32'(o_tx_byte), 32'(vecs[v].exp_byte));
            chk($sformatf("v%0d_ready", v), 32'(o_req_ready), 32'(vecs[v].exp_grant));
            i_req_valid = '0;
            expect_frame($sformatf("v%0d", v), vecs[v].exp_byte);
            @(negedge clk_50M);
            chk($sformatf("v%0d_release", v), 32'(o_grant), 0);
        end

        // contention: every requester held until its own ready
        base = rdy_cnt;
        i_req_valid = 4'b1111;
        i_req_data  = 32'hA3A2_A1A0;
        for (int i = 0; i < 4; i++) begin
            wait_avail(10, ok, cyc);
            chk($sformatf("cont%0d_launch", i), 32'(ok), 1);
            chk($sformatf("cont%0d_grant", i), 32'(o_grant), 32'(4'b0001 << i));
            i_req_valid = i_req_valid & ~o_req_ready;
            expect_frame($sformatf("cont%0d", i), 8'hA0 + 8'(i));
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("cont_ready_cnt%0d", k), 32'(rdy_cnt[k] - base[k]), 1);

        // fairness: req1 and req3 never drop valid
        base = rdy_cnt;
        i_req_valid = 4'b1010;
        i_req_data  = 32'h6300_6100;
        for (int i = 0; i < 4; i++) begin
            wait_avail(10, ok, cyc);
            chk($sformatf("fair%0d_grant", i), 32'(o_grant), 32'(exp_f[i]));
            if (i == 3) i_req_valid = '0;
            expect_frame($sformatf("fair%0d", i), (exp_f[i] == 4'b0010) ? 8'h61 : 8'h63);
        end
        chk("fair_cnt0", 32'(rdy_cnt[0] - base[0]), 0);
        chk("fair_cnt1", 32'(rdy_cnt[1] - base[1]), 2);
        chk("fair_cnt2", 32'(rdy_cnt[2] - base[2]), 0);
        chk("fair_cnt3", 32'(rdy_cnt[3] - base[3]), 2);

        // timeout: transmitter never raises busy
        tx_mute = 1'b1;
        i_req_valid = 4'b0001;
        i_req_data  = 32'h0000_0077;
        wait_avail(10, ok, cyc);
        chk("to_launch", 32'(ok), 1);
        repeat (8) @(negedge clk_50M);
        chk("to_err_early", 32'(o_err), 0);
        chk("to_grant_held", 32'(o_grant), 32'(4'b0001));
        @(negedge clk_50M);
        chk("to_err_set", 32'(o_err), 1);
        chk("to_grant_clr", 32'(o_grant), 0);
        tx_mute = 1'b0;
        wait_avail(4, ok, cyc);
        chk("to_relaunch", 32'(ok), 1);
        chk("to_relaunch_byte", 32'(o_tx_byte), 32'h77);
        i_req_valid = '0;
        expect_frame("to_frame", 8'h77);
        chk("to_err_sticky", 32'(o_err), 1);

        // reset in the middle of a frame
        i_req_valid = 4'b0010;
        i_req_data  = 32'h0000_3C00;
        wait_avail(10, ok, cyc);
        i_req_valid = '0;
        repeat (6) @(negedge clk_50M);
        chk("mid_grant_before", 32'(o_grant), 32'(4'b0010));
        i_rst = 1'b1;
        #1;
        chk("mid_rst_avail", 32'(o_tx_avail), 0);
        chk("mid_rst_ready", 32'(o_req_ready), 0);
        chk("mid_rst_byte", 32'(o_tx_byte), 0);
        chk("mid_rst_grant", 32'(o_grant), 0);
        chk("mid_rst_err", 32'(o_err), 0);
        @(negedge clk_50M);
        i_rst = 1'b0;
        i_req_valid = 4'b1111;
        i_req_data  = 32'hE3E2_E1E0;
        launched = 1'b0;
        cyc = 0;
        while (tx_busy && cyc < 80) begin
            @(negedge clk_50M);
            if (o_tx_avail) launched = 1'b1;
            cyc++;
        end
        chk("mid_busy_fell", 32'(tx_busy), 0);
        chk("mid_no_overlap", 32'(launched), 0);
        chk("mid_old_frame", 32'(last_sent), 32'h3C);
        wait_avail(4, ok, cyc);
        chk("mid_launch", 32'(ok), 1);
        chk("mid_grant0", 32'(o_grant), 32'(4'b0001));
        i_req_valid = '0;
        expect_frame("mid_frame", 8'hE0);

`ifdef UART_TX_ARB_LOCK_EN
        i_rst = 1'b1;
        @(negedge clk_50M);
        i_rst = 1'b0;
        i_req_valid = 4'b0011;
        i_req_last  = 4'b0000;
        i_req_data  = 32'h0000_91C0;
        for (int b = 0; b < 3; b++) begin
            wait_avail(10, ok, cyc);
            chk($sformatf("lock%0d_grant", b), 32'(o_grant), 32'(4'b0001));
            i_req_data[7:0] = 8'hC1 + 8'(b);
            if (b == 1) i_req_last[0] = 1'b1;
            expect_frame($sformatf("lock%0d", b), 8'hC0 + 8'(b));
        end
        wait_avail(10, ok, cyc);
        chk("lock_next_grant", 32'(o_grant), 32'(4'b0010));
        i_req_valid = '0;
        expect_frame("lock_next", 8'h91);
`else
        // without packet lock a non-last byte does not keep ownership
        i_req_valid = 4'b0011;
        i_req_last  = 4'b0000;
        i_req_data  = 32'h0000_9190;
        wait_avail(10, ok, cyc);
        chk("nolock_grant_a", 32'(o_grant), 32'(4'b0010));
        expect_frame("nolock_a", 8'h91);
        wait_avail(10, ok, cyc);
        chk("nolock_grant_b", 32'(o_grant), 32'(4'b0001));
        i_req_valid = '0;
        expect_frame("nolock_b", 8'h90);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
